// File: rtl/line_delay.sv
// line_delay: fixed-latency sample delay line, register chain or circular RAM chosen from DELAY.
// Defining LINE_DELAY_VALID_EN adds a registered valid_out that rises once the line has filled.
module line_delay #(
    parameter int DATA_W        = 8,
    parameter int DELAY         = 4,
    parameter int RAM_THRESHOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] value_in,
    output logic [DATA_W-1:0] value_out
`ifdef LINE_DELAY_VALID_EN
    ,
    output logic              valid_out
`endif
);
    localparam bit USE_RAM = (DELAY > RAM_THRESHOLD) && (DELAY > 1);
    localparam int CNT_W   = (DELAY > 1) ? $clog2(DELAY) : 1;
`ifdef LINE_DELAY_VALID_EN
    localparam bit NEED_FILL = 1'b1;
`else
    localparam bit NEED_FILL = USE_RAM;
`endif

    generate
        if (DELAY < 1) begin : g_bad_delay
            $error("line_delay: DELAY must be >= 1");
        end

        // Fill counter saturates at DELAY-1; done marks that real data is arriving at the output.
        if (NEED_FILL) begin : g_fill
            logic [CNT_W-1:0] fill_q, fill_d;
            logic             done;
            assign done   = (fill_q == CNT_W'(DELAY - 1));
            assign fill_d = done ? fill_q : fill_q + CNT_W'(1);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) fill_q <= '0;
                else        fill_q <= fill_d;
            end
        end

        if (!USE_RAM) begin : g_chain
            logic [DELAY-1:0][DATA_W-1:0] stage_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q[0] <= value_in;
                    for (int i = 1; i < DELAY; i++) stage_q[i] <= stage_q[i-1];
                end
            end
            assign value_out = stage_q[DELAY-1];
        end else begin : g_ram
            // DELAY-1 RAM entries plus the output register give exactly DELAY cycles.
            localparam int DEPTH = DELAY - 1;
            localparam int PTR_W = $clog2(DELAY);
            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  ptr_q, ptr_d;
            logic [DATA_W-1:0] out_q;

            assign ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

            always_ff @(posedge clk) begin
                mem[ptr_q] <= value_in;
            end

            // Read-first: the entry at ptr_q is the sample written DELAY-1 edges ago.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q <= '0;
                    out_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                    out_q <= g_fill.done ? mem[ptr_q] : '0;
                end
            end
            assign value_out = out_q;
        end
    endgenerate

`ifdef LINE_DELAY_VALID_EN
    logic valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= 1'b0;
        else        valid_q <= g_fill.done;
    end
    assign valid_out = valid_q;
`endif

endmodule

// File: tb/tb_line_delay.sv
// Directed bench for line_delay: chain, single-register, RAM with wrap, chain/RAM equivalence, mid-stream reset.
module tb_line_delay;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] o4, o1, o40, o17r, o17c;
    int checks = 0;
    int failures = 0;
`ifdef LINE_DELAY_VALID_EN
    logic v4, v1, v40, v17r, v17c;
`endif

    always #5 clk = ~clk;

    line_delay #(.DATA_W(8), .DELAY(4), .RAM_THRESHOLD(16)) u_d4 (
        .clk(clk), .rst_n(rst_n), .value_in(din), .value_out(o4)
`ifdef LINE_DELAY_VALID_EN
        , .valid_out(v4)
`endif
    );
    line_delay #(.DATA_W(8), .DELAY(1), .RAM_THRESHOLD(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .value_in(din), .value_out(o1)
`ifdef LINE_DELAY_VALID_EN
        , .valid_out(v1)
`endif
    );
    line_delay #(.DATA_W(8), .DELAY(40), .RAM_THRESHOLD(16)) u_d40 (
        .clk(clk), .rst_n(rst_n), .value_in(din), .value_out(o40)
`ifdef LINE_DELAY_VALID_EN
        , .valid_out(v40)
`endif
    );
    line_delay #(.DATA_W(8), .DELAY(17), .RAM_THRESHOLD(16)) u_d17r (
        .clk(clk), .rst_n(rst_n), .value_in(din), .value_out(o17r)
`ifdef LINE_DELAY_VALID_EN
        , .valid_out(v17r)
`endif
    );
    line_delay #(.DATA_W(8), .DELAY(17), .RAM_THRESHOLD(32)) u_d17c (
        .clk(clk), .rst_n(rst_n), .value_in(din), .value_out(o17c)
`ifdef LINE_DELAY_VALID_EN
        , .valid_out(v17c)
`endif
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp4;
        logic [7:0] exp1;
        logic       expv4;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din   = 8'd0;
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] hist [1:80];
    logic [7:0] exp17;

    initial begin
        tv[0] = '{8'd11, 8'd0,  8'd11, 1'b0};
        tv[1] = '{8'd22, 8'd0,  8'd22, 1'b0};
        tv[2] = '{8'd33, 8'd0,  8'd33, 1'b0};
        tv[3] = '{8'd44, 8'd11, 8'd44, 1'b1};
        tv[4] = '{8'd55, 8'd22, 8'd55, 1'b1};
        tv[5] = '{8'd66, 8'd33, 8'd66, 1'b1};
        tv[6] = '{8'd77, 8'd44, 8'd77, 1'b1};
        tv[7] = '{8'd0,  8'd55, 8'd0,  1'b1};
        tv[8] = '{8'd0,  8'd66, 8'd0,  1'b1};
        tv[9] = '{8'd0,  8'd77, 8'd0,  1'b1};

        // Reset state
        repeat (3) step();
        chk("rst_o4", 32'(o4), 32'd0);
        chk("rst_o1", 32'(o1), 32'd0);
        chk("rst_o40", 32'(o40), 32'd0);
        chk("rst_o17r", 32'(o17r), 32'd0);
        chk("rst_o17c", 32'(o17c), 32'd0);
`ifdef LINE_DELAY_VALID_EN
        chk("rst_v4", 32'(v4), 32'd0);
`endif
        rst_n = 1'b1;

        // DELAY=4 and DELAY=1 table
        for (int i = 0; i < 10; i++) begin
            din = tv[i].din;
            step();
            chk($sformatf("d4_e%0d", i + 1), 32'(o4), 32'(tv[i].exp4));
            chk($sformatf("d1_e%0d", i + 1), 32'(o1), 32'(tv[i].exp1));
`ifdef LINE_DELAY_VALID_EN
            chk($sformatf("v4_e%0d", i + 1), 32'(v4), 32'(tv[i].expv4));
            chk($sformatf("v1_e%0d", i + 1), 32'(v1), 32'd1);
`endif
        end

        // Ramp through DELAY=40 RAM path across several pointer wraps
        do_reset();
        for (int e = 1; e <= 125; e++) begin
            din = 8'(e);
            step();
            if (e <= 45 || e == 79 || e == 80 || e == 119 || e == 125) begin
                chk($sformatf("d40_e%0d", e), 32'(o40), (e >= 40) ? 32'(e - 39) : 32'd0);
                chk($sformatf("d17r_ramp_e%0d", e), 32'(o17r), (e >= 17) ? 32'(e - 16) : 32'd0);
`ifdef LINE_DELAY_VALID_EN
                chk($sformatf("v40_e%0d", e), 32'(v40), (e >= 40) ? 32'd1 : 32'd0);
`endif
            end
        end

        // Random stream: RAM-mode and chain-mode DELAY=17 against recorded history
        do_reset();
        for (int e = 1; e <= 80; e++) begin
            din = 8'($urandom_range(255));
            hist[e] = din;
            step();
            exp17 = (e >= 17) ? hist[e-16] : 8'd0;
            if (e >= 14) begin
                chk($sformatf("d17r_e%0d", e), 32'(o17r), 32'(exp17));
                chk($sformatf("d17c_e%0d", e), 32'(o17c), 32'(exp17));
`ifdef LINE_DELAY_VALID_EN
                chk($sformatf("v17r_e%0d", e), 32'(v17r), (e >= 17) ? 32'd1 : 32'd0);
                chk($sformatf("v17c_e%0d", e), 32'(v17c), (e >= 17) ? 32'd1 : 32'd0);
`endif
            end
        end

        // Mid-stream asynchronous reset
        do_reset();
        for (int e = 1; e <= 8; e++) begin
            din = 8'hA5;
            step();
        end
        chk("mid_pre_o4", 32'(o4), 32'hA5);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_async_o4", 32'(o4), 32'd0);
        chk("mid_async_o1", 32'(o1), 32'd0);
        chk("mid_async_o40", 32'(o40), 32'd0);
`ifdef LINE_DELAY_VALID_EN
        chk("mid_async_v4", 32'(v4), 32'd0);
`endif
        #2 rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk($sformatf("mid_o4_e%0d", e), 32'(o4), (e >= 4) ? 32'hA5 : 32'd0);
            chk($sformatf("mid_o1_e%0d", e), 32'(o1), 32'hA5);
`ifdef LINE_DELAY_VALID_EN
            chk($sformatf("mid_v4_e%0d", e), 32'(v4), (e >= 4) ? 32'd1 : 32'd0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/line_delay.md
Name: line_delay

Overview:
- Fixed-latency pixel/sample delay line: every sample entering on `value_in` reappears on `value_out` exactly DELAY clock cycles later.
- Used in the median-filter datapath to align image rows; DELAY is typically the line width, so it can be large.
- Two storage architectures (register chain or circular RAM), chosen at elaboration from DELAY. Observable behaviour is identical for both.

Parameters:
- DATA_W, 8, bit width of each sample.
- DELAY, 4, latency in clock cycles; legal range 1..65536; elaboration error if DELAY < 1.
- RAM_THRESHOLD, 16, if DELAY <= RAM_THRESHOLD use a register chain, else a circular buffer memory.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value_in  input  DATA_W  sample in; sampled on every rising edge (no enable).
- value_out  output  DATA_W  delayed sample; registered output.

Behaviour:
- Reset, asynchronous (rst_n low):
  - value_out = 0.
  - All chain registers = 0.
  - Write pointer = 0, fill counter = 0.
  - RAM contents are not cleared.
- Reset release: first sampling edge is the first rising edge with rst_n high.
- Latency:
  - A sample captured at rising edge k drives value_out from just after edge k+DELAY-1 until just after edge k+DELAY.
  - DELAY = 1 is a single register.
  - Throughput is one sample per cycle, continuous, with no stall.
- Pre-fill: until DELAY samples have been captured since reset, value_out = 0, never X. Same for both architectures.
- Register-chain architecture (DELAY <= RAM_THRESHOLD):
  - DELAY-stage shift register; stage 0 loads value_in; value_out = last stage.
  - Zero-fill comes naturally from reset.
- RAM architecture (DELAY > RAM_THRESHOLD):
  - Memory depth DELAY-1; write pointer width clog2(DELAY).
  - Each edge: read the entry at the pointer into the output register, write value_in at the same pointer (read-before-write), advance the pointer.
  - Pointer wraps from DELAY-2 to 0; depth is not required to be a power of two.
  - Fill counter saturates at DELAY-1; while it is below DELAY-1 the output register loads 0 instead of RAM data.
  - Must infer simple dual-port or single-port read-first block RAM; no combinational RAM-to-output path.
- X on value_in propagates unchanged; no sanitising.
- Reset asserted mid-stream:
  - value_out goes to 0 immediately.
  - All data in flight is discarded: post-reset output is 0 for DELAY-1 edges, then new data.
- Arithmetic: none. Data is passed bit-exact.

Optional Feature:
- Macro LINE_DELAY_VALID_EN.
- When defined, adds output port `valid_out` (1 bit, registered).
  - Reset value 0.
  - Goes high just after the edge where the first post-reset sample reaches value_out (edge DELAY after reset release, counting the first sampling edge as 1).
  - Stays high until the next reset.
  - The fill counter is shared with the RAM path.
- When not defined: no valid_out port and no extra logic. In chain mode no fill counter exists at all.

Test Plan:
- DELAY=4, DATA_W=8; inputs 11,22,33,44,55,66,77 on consecutive edges 1..7 after reset -> value_out is 0 after edges 1-3, 11 after edge 4, 22 after 5, ... 77 after edge 10.
- DELAY=1 -> value_out equals the previous edge's value_in every cycle; 0 after the first edge following reset only if value_in was 0.
- DELAY=40 (RAM path, non-power-of-two); ramp input 1,2,3,... -> value_out = 0 for edges 1-39, then 1 after edge 40, 2 after 41, continuing across pointer wrap (edges 79, 80, 119) with no gap or duplicate.
- Mid-stream reset: DELAY=4, streaming 0xA5; pulse rst_n low for 3 ns between edges -> value_out goes 0 asynchronously, stays 0 for 3 edges, shows new data at the 4th.
- Chain vs RAM equivalence: DELAY=17 with RAM_THRESHOLD=16 and RAM_THRESHOLD=32, same random stream -> outputs identical cycle by cycle.
- LINE_DELAY_VALID_EN defined, DELAY=4 -> valid_out 0 after edges 1-3, 1 after edge 4 and onward; drops to 0 asynchronously on reset.
